mem_resp: RTL and testbench
===========================

MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameter DEPTH, default 256; memory size in 32-bit words, power of two.
REQ-002 Parameter WAIT_CYCLES, default 2; wait states inserted before each response, legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req  input  1  CPU access request; held high by the CPU until ready is seen.
REQ-006 IorD  input  1  access source tag: 0 = instruction fetch (PC), 1 = data (ALU address).
REQ-007 we  input  1  write enable; 1 = store, 0 = load.
REQ-008 addr  input  32  byte address; word index = addr[log2(DEPTH)+1:2].
REQ-009 wdata  input  32  store data.
REQ-010 rdata  output  32  load data; valid only while ready = 1.
REQ-011 ready  output  1  one-cycle response strobe.
REQ-012 busy  output  1  high from request acceptance until ready has been asserted.
REQ-013 src  output  1  IorD captured at acceptance; valid while ready = 1.
REQ-014 err  output  1  misaligned-access flag; valid while ready = 1.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; all outputs driven from registers.
REQ-016 IDLE with req = 1 at edge k: capture addr, we, wdata and IorD; set busy.
- Next state is WAIT with the counter loaded to WAIT_CYCLES-1.
- If WAIT_CYCLES = 0, next state is RESP.
REQ-017 WAIT: counter decrements each edge; at counter = 0, next state is RESP.
REQ-018 ready is high during exactly one cycle, WAIT_CYCLES+1 cycles after edge k.
REQ-019 On the edge entering RESP:
- load: rdata <= mem[index].
- store: mem[index] <= wdata and rdata <= 0.
REQ-020 RESP to IDLE unconditionally; busy clears on that same edge.
REQ-021 A new req is sampled only in IDLE, so back-to-back accesses are spaced by at least WAIT_CYCLES+2 cycles.
REQ-022 req, addr and input changes while in WAIT or RESP are ignored; captured values govern the access.
REQ-023 Address bits above the index wrap modulo DEPTH; no out-of-range error is raised.
REQ-024 IorD does not alter timing or data path; it is returned on src only.
REQ-025 Fetch and data accesses share one memory; a store is visible to the next fetch at the same address.

Reset
REQ-026 With rst_n = 0 at an edge:
- state goes to IDLE.
- ready, busy, err and src go to 0; rdata goes to 0; counter goes to 0.
REQ-027 Reset mid-access aborts the access: no write is committed if reset coincides with the RESP-entry edge, and no ready is issued.
REQ-028 Memory contents are not cleared by reset.

Configuration
REQ-029 Macro MEM_RESP_ALIGN_CHK_EN.
- Defined: captured addr[1:0] != 0 sets err = 1 together with ready; a misaligned store is suppressed and rdata = 0.
- Undefined: addr[1:0] is ignored and err is tied to 0.

Structure
REQ-030 Shared package mem_pkg holds:
- FSM state enum (IDLE/WAIT/RESP);
- word width constant 32;
- IorD encodings IORD_INSTR = 0 and IORD_DATA = 1.
REQ-031 The storage array is a sub-module mem_array: single-port, synchronous write, registered read; mem_resp holds the FSM and counter.

Verification
REQ-032 WAIT_CYCLES = 2; store 0xDEADBEEF at 0x10, then load 0x10 -> ready 3 cycles after each acceptance, load rdata = 0xDEADBEEF.
REQ-033 WAIT_CYCLES = 0; fetch (IorD = 0) at 0x0 after preload 0x12345678 -> ready the next cycle, rdata = 0x12345678, src = 0.
REQ-034 req held high across a response, addr changed during WAIT -> second access starts only after return to IDLE and uses the captured addr.
REQ-035 rst_n = 0 in WAIT of a store to 0x20 -> no ready pulse, busy = 0, mem[0x20] unchanged.
REQ-036 DEPTH = 256; store to 0x400 then load 0x000 -> same word returned (wrap).
REQ-037 Macro defined; store to 0x13 -> err = 1 with ready, memory unchanged; macro undefined -> err = 0 and the word at 0x10 is written.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory responder (mem_resp / mem_array).
package mem_pkg;

    localparam int WORD_W = 32;

    // Access source tag carried on IorD and returned on src.
    localparam logic IORD_INSTR = 1'b0;
    localparam logic IORD_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Everything the access needs, frozen at acceptance.
    typedef struct packed {
        logic              we;
        logic              iord;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } acc_t;

    function automatic logic is_misaligned(input logic [WORD_W-1:0] byte_addr);
        return byte_addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, registered read. An access with
// neither read nor write enabled returns zero on rdata_o.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // NOTE: the storage array has no reset branch; contents survive rst_n and a
    // reset loop over DEPTH entries would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (acc_i && wr_en_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (acc_i) begin
            rdata_q <= rd_en_i ? mem_q[idx_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_resp.sv
// CPU-facing memory responder: accepts a request in IDLE, waits WAIT_CYCLES, then
// pulses ready for one cycle. Define MEM_RESP_ALIGN_CHK_EN to flag misaligned accesses.
module mem_resp
    import mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              IorD,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              src,
    output logic              err
);

    localparam int AW = $clog2(DEPTH);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    acc_t       acc_q, acc_live, acc_cur;
    logic       busy_q, busy_d;
    logic       ready_q, err_q, src_q;
    logic       capture, enter_resp, misaligned;
    logic       unused_bits;

    assign acc_live = '{we: we, iord: IorD, addr: addr, wdata: wdata};

    // With zero wait states RESP is entered on the acceptance edge itself, so the
    // memory must see the live inputs rather than the not-yet-captured copy.
    assign acc_cur = (state_q == IDLE) ? acc_live : acc_q;

`ifdef MEM_RESP_ALIGN_CHK_EN
    assign misaligned  = is_misaligned(acc_cur.addr);
    assign unused_bits = ^{acc_cur.addr[WORD_W-1:AW+2], acc_cur.iord};
`else
    assign misaligned  = 1'b0;
    assign unused_bits = ^{acc_cur.addr[WORD_W-1:AW+2], acc_cur.addr[1:0], acc_cur.iord};
`endif

    // NOTE: every always_comb output gets a default before the case so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        capture    = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    busy_d  = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            src_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ready_q <= enter_resp;
            err_q   <= enter_resp & misaligned;
            if (capture) begin
                acc_q <= acc_live;
                src_q <= acc_live.iord;
            end
        end
    end

    // Reset on the RESP-entry edge must not commit a store.
    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc_i   (enter_resp & rst_n),
        .wr_en_i (acc_cur.we & ~misaligned),
        .rd_en_i (~acc_cur.we & ~misaligned),
        .idx_i   (acc_cur.addr[AW+1:2]),
        .wdata_i (acc_cur.wdata),
        .rdata_o (rdata)
    );

    assign ready = ready_q;
    assign busy  = busy_q;
    assign src   = src_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: two instances (2 and 0 wait states) driven by
// directed and random accesses, compared against a word-array reference model.
module tb_mem_resp;
    import mem_pkg::*;

    localparam int DEPTH = 256;
    localparam int NU    = 2;
    localparam int WC [NU] = '{2, 0};

    logic        clk = 1'b0;
    logic        rst_n [NU];
    logic        req   [NU];
    logic        iord  [NU];
    logic        we    [NU];
    logic [31:0] addr  [NU];
    logic [31:0] wdata [NU];
    logic [31:0] rdata [NU];
    logic        ready [NU];
    logic        busy  [NU];
    logic        src   [NU];
    logic        err   [NU];

    logic [31:0] model [NU][DEPTH];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .IorD(iord[0]), .we(we[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]),
        .busy(busy[0]), .src(src[0]), .err(err[0])
    );

    mem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .IorD(iord[1]), .we(we[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]),
        .busy(busy[1]), .src(src[1]), .err(err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_misaligned(input logic [31:0] a);
`ifdef MEM_RESP_ALIGN_CHK_EN
        return (a % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // One complete access; hold keeps req high and scrambles inputs after acceptance.
    task automatic do_access(input int u, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic tag, input bit hold);
        int          n;
        int          word;
        logic [31:0] exp_rd;
        bit          mis;
        word = int'((a / 4) % DEPTH);
        mis  = model_misaligned(a);
        @(negedge clk);
        check("idle_busy", {31'd0, busy[u]}, 32'd0);
        req[u] = 1'b1; we[u] = w; addr[u] = a; wdata[u] = d; iord[u] = tag;
        @(posedge clk); #1;
        check("busy_after_accept", {31'd0, busy[u]}, 32'd1);
        if (hold) begin
            addr[u] = $urandom; wdata[u] = $urandom; we[u] = 1'($urandom); iord[u] = 1'($urandom);
        end else begin
            req[u] = 1'b0;
        end
        n = 0;
        while (!ready[u] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_latency", 32'(n), 32'(WC[u]));
        if (mis) begin
            exp_rd = 32'd0;
        end else if (w) begin
            exp_rd = 32'd0;
            model[u][word] = d;
        end else begin
            exp_rd = model[u][word];
        end
        check("rdata", rdata[u], exp_rd);
        check("src", {31'd0, src[u]}, {31'd0, tag});
        check("err", {31'd0, err[u]}, {31'd0, mis});
        @(posedge clk); #1;
        check("ready_one_cycle", {31'd0, ready[u]}, 32'd0);
        check("busy_cleared", {31'd0, busy[u]}, 32'd0);
        req[u] = 1'b0;
    endtask

    initial begin
        logic [31:0] pool [8];
        bit          saw_ready;
        for (int u = 0; u < NU; u++) begin
            rst_n[u] = 1'b0; req[u] = 1'b0; iord[u] = 1'b0; we[u] = 1'b0;
            addr[u] = '0; wdata[u] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < NU; u++) begin
            check("rst_ready", {31'd0, ready[u]}, 32'd0);
            check("rst_busy",  {31'd0, busy[u]},  32'd0);
            check("rst_err",   {31'd0, err[u]},   32'd0);
            check("rst_src",   {31'd0, src[u]},   32'd0);
            check("rst_rdata", rdata[u], 32'd0);
        end
        @(negedge clk);
        for (int u = 0; u < NU; u++) rst_n[u] = 1'b1;

        // Store then load at 0x10 with two wait states.
        do_access(0, 1'b1, 32'h10, 32'hDEADBEEF, IORD_DATA, 1'b0);
        do_access(0, 1'b0, 32'h10, 32'h0, IORD_DATA, 1'b0);
        // Zero wait states: preload 0x0, then instruction fetch.
        do_access(1, 1'b1, 32'h0, 32'h12345678, IORD_DATA, 1'b0);
        do_access(1, 1'b0, 32'h0, 32'h0, IORD_INSTR, 1'b0);
        // req held and inputs scrambled during WAIT: captured address governs.
        do_access(0, 1'b0, 32'h10, 32'h0, IORD_DATA, 1'b1);
        do_access(1, 1'b0, 32'h0, 32'h0, IORD_INSTR, 1'b1);
        // Address wrap modulo DEPTH.
        for (int u = 0; u < NU; u++) begin
            do_access(u, 1'b1, 32'h400, 32'hA5A5_0400, IORD_DATA, 1'b0);
            do_access(u, 1'b0, 32'h000, 32'h0, IORD_DATA, 1'b0);
        end
        // Misaligned store to 0x13, then read back the word at 0x10.
        for (int u = 0; u < NU; u++) begin
            do_access(u, 1'b1, 32'h10, 32'h1111_1010, IORD_DATA, 1'b0);
            do_access(u, 1'b1, 32'h13, 32'h2222_1313, IORD_DATA, 1'b0);
            do_access(u, 1'b0, 32'h10, 32'h0, IORD_DATA, 1'b0);
        end

        // Reset landing on the RESP-entry edge of a store to 0x20 aborts it.
        do_access(0, 1'b1, 32'h20, 32'hCAFE_0020, IORD_DATA, 1'b0);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hBAD0_0BAD;
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n[0] = 1'b0;
        @(posedge clk); #1;
        check("abort_ready", {31'd0, ready[0]}, 32'd0);
        check("abort_busy",  {31'd0, busy[0]},  32'd0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        saw_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ready[0]) saw_ready = 1'b1;
        end
        check("abort_no_ready", {31'd0, saw_ready}, 32'd0);
        do_access(0, 1'b0, 32'h20, 32'h0, IORD_DATA, 1'b0);

        // Random traffic over a preloaded pool of words.
        for (int i = 0; i < 8; i++) pool[i] = 32'((i * 29 + 3) % DEPTH) * 4;
        for (int u = 0; u < NU; u++) begin
            for (int i = 0; i < 8; i++) do_access(u, 1'b1, pool[i], $urandom, IORD_DATA, 1'b0);
            for (int i = 0; i < 60; i++) begin
                logic [31:0] a;
                a = pool[$urandom_range(7)] | ($urandom << 10);
                if ($urandom_range(3) == 0) a[1:0] = 2'($urandom_range(3, 1));
                do_access(u, 1'($urandom), a, $urandom, 1'($urandom), 1'($urandom_range(3) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
